// File: rtl/ac_motor_gate_driver_pkg.sv
// Shared constants and types for the AC motor gate driver: SVPWM vector table,
// leg state encoding and default dead-time settings.
package ac_motor_pkg;

    localparam int SECTOR_COUNT        = 6;
    localparam int DEAD_CYCLES_DEFAULT = 50;
    localparam int CNT_W_DEFAULT       = 8;

    // Active vectors as {A,B,C}; 1 = high switch conducting.
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;

    typedef enum logic [1:0] {
        LEG_OFF     = 2'd0,
        LEG_LOW_ON  = 2'd1,
        LEG_DEAD    = 2'd2,
        LEG_HIGH_ON = 2'd3
    } leg_state_t;

    // Sector s maps u1 to V(s+1) and u2 to the next vector, wrapping V6 -> V1.
    function automatic logic [2:0] sector_vector(input logic [2:0] sector,
                                                 input logic       second);
        logic [3:0] idx;
        idx = {1'b0, sector} + {3'b000, second};
        if (idx >= 4'(SECTOR_COUNT)) idx = idx - 4'(SECTOR_COUNT);
        case (idx)
            4'd0:    return V1;
            4'd1:    return V2;
            4'd2:    return V3;
            4'd3:    return V4;
            4'd4:    return V5;
            default: return V6;
        endcase
    endfunction

endpackage

// File: rtl/ac_motor_gate_leg.sv
// One inverter leg: OFF / LOW_ON / DEAD / HIGH_ON state machine with a
// dead-time counter, so the two switches of the leg never conduct together.
module ac_motor_gate_leg
    import ac_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic demand,
    output logic gate_h,
    output logic gate_l,
    output logic state_bit
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    leg_state_t       state_q, state_d;
    logic             target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            LEG_OFF: begin
                state_d  = LEG_DEAD;
                target_d = demand;
                cnt_d    = CNT_LOAD;
            end
            LEG_LOW_ON: begin
                if (demand) begin
                    state_d  = LEG_DEAD;
                    target_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                end
            end
            LEG_HIGH_ON: begin
                if (!demand) begin
                    state_d  = LEG_DEAD;
                    target_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                end
            end
            LEG_DEAD: begin
                // A demand change during dead time restarts the full interval.
                if (demand != target_q) begin
                    target_d = demand;
                    cnt_d    = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = target_q ? LEG_HIGH_ON : LEG_LOW_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = LEG_OFF;
        endcase
        if (!enable) state_d = LEG_OFF;
    end

    // Gates are decoded from the next state so they change on the same edge as
    // the state register and can never both be high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state_q   <= LEG_OFF;
            target_q  <= 1'b0;
            cnt_q     <= '0;
            gate_h    <= 1'b0;
            gate_l    <= 1'b0;
            state_bit <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            gate_h    <= (state_d == LEG_HIGH_ON);
            gate_l    <= (state_d == LEG_LOW_ON);
            state_bit <= (state_d == LEG_HIGH_ON);
        end
    end

endmodule

// File: rtl/ac_motor_gate_driver.sv
// Top level: switching-vector decode, sticky vector error and three dead-timed legs.
// Optional fault input/latch is built when AC_MOTOR_GATE_FAULT_EN is defined.
module ac_motor_gate_driver
    import ac_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] sector,
    input  logic       u0,
    input  logic       u1,
    input  logic       u2,
    input  logic       u7,
`ifdef AC_MOTOR_GATE_FAULT_EN
    input  logic       fault_n,
    output logic       fault,
`endif
    output logic       gate_ah,
    output logic       gate_al,
    output logic       gate_bh,
    output logic       gate_bl,
    output logic       gate_ch,
    output logic       gate_cl,
    output logic [2:0] phase_state,
    output logic       vec_err
);

    logic       sector_ok;
    logic       multi_strobe;
    logic       err_set;
    logic [2:0] demand_q, demand_d;
    logic       leg_enable;
    logic [2:0] gate_h_v, gate_l_v, state_bit_v;

    assign sector_ok    = (sector < 3'(SECTOR_COUNT));
    assign multi_strobe = (u0 & u1) | (u0 & u2) | (u0 & u7) |
                          (u1 & u2) | (u1 & u7) | (u2 & u7);
    assign err_set      = multi_strobe | (enable & ~sector_ok);

    // Active vectors need a valid sector; zero vectors do not.
    always_comb begin
        demand_d = demand_q;
        if (u0)                   demand_d = 3'b000;
        else if (u1 && sector_ok) demand_d = sector_vector(sector, 1'b0);
        else if (u2 && sector_ok) demand_d = sector_vector(sector, 1'b1);
        else if (u7)              demand_d = 3'b111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demand_q <= 3'b000;
            vec_err  <= 1'b0;
        end else begin
            demand_q <= demand_d;
            vec_err  <= vec_err | err_set;
        end
    end

`ifdef AC_MOTOR_GATE_FAULT_EN
    logic [1:0] fault_sync;
    logic       fault_n_s;

    assign fault_n_s = fault_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sync <= 2'b11;
            fault      <= 1'b0;
        end else begin
            fault_sync <= {fault_sync[0], fault_n};
            if (!fault_n_s)   fault <= 1'b1;
            else if (!enable) fault <= 1'b0;
        end
    end

    // The synchronized pin gates the legs directly so they reach OFF one cycle
    // before the latched flag would.
    assign leg_enable = enable & ~fault & fault_n_s;
`else
    assign leg_enable = enable;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_leg
        ac_motor_gate_leg #(
            .DEAD_CYCLES (DEAD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_leg (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (leg_enable),
            .demand    (demand_q[i]),
            .gate_h    (gate_h_v[i]),
            .gate_l    (gate_l_v[i]),
            .state_bit (state_bit_v[i])
        );
    end

    // Bit 2 is phase A, bit 0 is phase C.
    assign gate_ah     = gate_h_v[2];
    assign gate_al     = gate_l_v[2];
    assign gate_bh     = gate_h_v[1];
    assign gate_bl     = gate_l_v[1];
    assign gate_ch     = gate_h_v[0];
    assign gate_cl     = gate_l_v[0];
    assign phase_state = state_bit_v;

endmodule

// File: tb/tb_ac_motor_gate_driver.sv
// Directed bench for ac_motor_gate_driver with a due-cycle scoreboard and a
// continuous shoot-through monitor.
module tb_ac_motor_gate_driver;

    localparam int D = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] sector;
    logic       u0, u1, u2, u7;
    logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic [2:0] phase_state;
    logic       vec_err;
`ifdef AC_MOTOR_GATE_FAULT_EN
    logic       fault_n;
    logic       fault;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int overlap_cnt = 0;

    typedef struct {
        int         due;
        logic [9:0] exp;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ac_motor_gate_driver #(.DEAD_CYCLES(D), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sector      (sector),
        .u0          (u0),
        .u1          (u1),
        .u2          (u2),
        .u7          (u7),
`ifdef AC_MOTOR_GATE_FAULT_EN
        .fault_n     (fault_n),
        .fault       (fault),
`endif
        .gate_ah     (gate_ah),
        .gate_al     (gate_al),
        .gate_bh     (gate_bh),
        .gate_bl     (gate_bl),
        .gate_ch     (gate_ch),
        .gate_cl     (gate_cl),
        .phase_state (phase_state),
        .vec_err     (vec_err)
    );

    always @(negedge clk)
        if ((gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl))
            overlap_cnt++;

    function automatic logic [9:0] obs_now();
        return {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, phase_state, vec_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rel = 1 is the next rising edge.
    task automatic expect_at(input int rel, input logic [5:0] g, input logic [2:0] ps,
                             input logic e, input string tag);
        exp_t x;
        x.due = cyc + rel;
        x.exp = {g, ps, e};
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    check(sb[i].tag, 32'(obs_now()), 32'(sb[i].exp));
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic pulse(input logic a0, input logic a1, input logic a2, input logic a7);
        u0 = a0; u1 = a1; u2 = a2; u7 = a7;
        run(1);
        u0 = 1'b0; u1 = 1'b0; u2 = 1'b0; u7 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sector = 3'd0;
        u0 = 1'b0; u1 = 1'b0; u2 = 1'b0; u7 = 1'b0;
`ifdef AC_MOTOR_GATE_FAULT_EN
        fault_n = 1'b1;
`endif
        run(3);
        check("reset_state", 32'(obs_now()), 32'h0);
        rst_n = 1'b1;
        run(3);
        check("idle_disabled", 32'(obs_now()), 32'h0);

        // Enable from OFF: full dead time, then all lows.
        enable = 1'b1;
        expect_at(1,  6'b000000, 3'b000, 1'b0, "start_dead_first");
        expect_at(50, 6'b000000, 3'b000, 1'b0, "start_dead_last");
        expect_at(51, 6'b010101, 3'b000, 1'b0, "start_lows_on");
        pulse(1, 0, 0, 0);
        run(54);

        // s=0 u1 -> 100: al drops at N+1, ah at N+51.
        expect_at(1,  6'b010101, 3'b000, 1'b0, "u1_demand_edge");
        expect_at(2,  6'b000101, 3'b000, 1'b0, "u1_al_drop");
        expect_at(51, 6'b000101, 3'b000, 1'b0, "u1_dead_last");
        expect_at(52, 6'b100101, 3'b100, 1'b0, "u1_ah_on");
        pulse(0, 1, 0, 0);
        run(54);

        // s=0 u2 -> 110.
        expect_at(2,  6'b100001, 3'b100, 1'b0, "u2_bl_drop");
        expect_at(51, 6'b100001, 3'b100, 1'b0, "u2_dead_last");
        expect_at(52, 6'b101001, 3'b110, 1'b0, "u2_bh_on");
        pulse(0, 0, 1, 0);
        run(54);

        // u7 -> 111.
        expect_at(2,  6'b101000, 3'b110, 1'b0, "u7_cl_drop");
        expect_at(52, 6'b101010, 3'b111, 1'b0, "u7_all_high");
        pulse(0, 0, 0, 1);
        run(54);

        // Revert demand 20 cycles into dead time: counter restarts.
        expect_at(2,  6'b000000, 3'b000, 1'b0, "revert_all_dead");
        expect_at(52, 6'b000000, 3'b000, 1'b0, "revert_no_low");
        pulse(1, 0, 0, 0);
        run(19);
        expect_at(51, 6'b000000, 3'b000, 1'b0, "revert_dead_last");
        expect_at(52, 6'b101010, 3'b111, 1'b0, "revert_high_on");
        pulse(0, 0, 0, 1);
        run(54);

        // Sector 5 wraps: u1 -> V6, u2 -> V1.
        sector = 3'd5;
        expect_at(2,  6'b100010, 3'b101, 1'b0, "s5_u1_dead");
        expect_at(52, 6'b100110, 3'b101, 1'b0, "s5_u1_v6");
        pulse(0, 1, 0, 0);
        run(54);
        expect_at(2,  6'b100100, 3'b100, 1'b0, "s5_u2_dead");
        expect_at(52, 6'b100101, 3'b100, 1'b0, "s5_u2_v1");
        pulse(0, 0, 1, 0);
        run(54);

        // Invalid sector: u1 ignored, error set; u7 still honoured.
        sector = 3'd7;
        expect_at(1,  6'b100101, 3'b100, 1'b1, "inv_err_set");
        expect_at(52, 6'b100101, 3'b100, 1'b1, "inv_u1_ignored");
        pulse(0, 1, 0, 0);
        run(54);
        sector = 3'd6;
        expect_at(2,  6'b100000, 3'b100, 1'b1, "inv_u7_dead");
        expect_at(52, 6'b101010, 3'b111, 1'b1, "inv_u7_sticky");
        pulse(0, 0, 0, 1);
        sector = 3'd0;
        run(54);

        // Disable forces OFF on the next edge.
        enable = 1'b0;
        expect_at(1, 6'b000000, 3'b000, 1'b1, "disable_off");
        run(3);

        // Reset clears the sticky error asynchronously.
        rst_n = 1'b0;
        #1;
        check("reset_clears_err", 32'(obs_now()), 32'h0);
        run(2);
        rst_n = 1'b1;
        run(2);

        // Re-enable with no strobes: held demand 000.
        sector = 3'd1;
        enable = 1'b1;
        expect_at(1,  6'b000000, 3'b000, 1'b0, "reenable_dead");
        expect_at(51, 6'b010101, 3'b000, 1'b0, "reenable_lows");
        run(54);

        // u1 & u2 together at s=1: error, u1 (V2=110) wins.
        expect_at(1,  6'b010101, 3'b000, 1'b1, "multi_err_set");
        expect_at(2,  6'b000001, 3'b000, 1'b1, "multi_dead");
        expect_at(52, 6'b101001, 3'b110, 1'b1, "multi_u1_wins");
        pulse(0, 1, 1, 0);
        run(54);

`ifdef AC_MOTOR_GATE_FAULT_EN
        fault_n = 1'b0;
        expect_at(3, 6'b000000, 3'b000, 1'b1, "fault_gates_off");
        run(3);
        check("fault_latched", 32'(fault), 32'd1);
        fault_n = 1'b1;
        run(5);
        check("fault_held_enabled", 32'({fault, obs_now()}), 32'({1'b1, 6'b000000, 3'b000, 1'b1}));
        enable = 1'b0;
        run(1);
        check("fault_cleared", 32'(fault), 32'd0);
`endif

        check("no_shoot_through", 32'(overlap_cnt), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
